// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [0:0] {
    IF_REQ    = 1'b0,
    IF_HALTED = 1'b1
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] PC_plus_4;
  } if_id_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer that parks a fetched word while the pipeline is frozen.
module if_hold_buf
  import if_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   drain,
  input  logic   clear,
  input  if_id_t din,
  output if_id_t dout,
  output logic   hold_valid
);

  // Clear and drain both empty the slot; clear wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      dout       <= '0;
    end else if (clear || drain) begin
      hold_valid <= 1'b0;
    end else if (load) begin
      hold_valid <= 1'b1;
      dout       <= din;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request handshake, freeze hold buffer and IF/ID register.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instruction,
  output logic [31:0] PC_plus_4,
  output logic        inst_valid,
  output logic        halted
);

  if_state_t   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_pc, drop_pc_nxt;
  logic        drop, drop_nxt;
  if_id_t      ifid, ifid_nxt;
  logic        valid_nxt, halted_nxt;
  logic        hold_load, hold_drain, hold_clear, hold_valid;
  if_id_t      hold_dout, fetched;
  logic        complete, sample;

  assign imem_req  = (state == IF_REQ) && !hold_valid && !rst;
  assign imem_addr = pc;
  assign complete  = imem_req && imem_ready;
  assign sample    = !cache_done && (state == IF_REQ);
  assign fetched   = {imem_data, pc + PC_INC};

  if_hold_buf u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .drain      (hold_drain),
    .clear      (hold_clear),
    .din        (fetched),
    .dout       (hold_dout),
    .hold_valid (hold_valid)
  );

  // Next-state: redirect beats halt; a redirect during an unanswered request
  // keeps the address stable and parks the target until the stale reply lands.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    drop_nxt    = drop;
    drop_pc_nxt = drop_pc;
    ifid_nxt    = ifid;
    valid_nxt   = inst_valid;
    halted_nxt  = halted;
    hold_load   = 1'b0;
    hold_drain  = 1'b0;
    hold_clear  = 1'b0;
    if (sample && redirect) begin
      valid_nxt  = 1'b0;
      hold_clear = 1'b1;
      if (imem_req && !imem_ready) begin
        drop_nxt    = 1'b1;
        drop_pc_nxt = redirect_pc;
      end else begin
        drop_nxt = 1'b0;
        pc_nxt   = redirect_pc;
      end
    end else if (sample && halt) begin
      state_nxt  = IF_HALTED;
      halted_nxt = 1'b1;
      valid_nxt  = 1'b0;
      hold_clear = 1'b1;
      drop_nxt   = 1'b0;
    end else if (complete && drop) begin
      drop_nxt = 1'b0;
      pc_nxt   = drop_pc;
      if (!cache_done) valid_nxt = 1'b0;
    end else if (complete) begin
      pc_nxt = pc + PC_INC;
      if (cache_done) begin
        hold_load = 1'b1;
      end else begin
        ifid_nxt  = fetched;
        valid_nxt = 1'b1;
      end
    end else if (!cache_done && hold_valid) begin
      ifid_nxt   = hold_dout;
      valid_nxt  = 1'b1;
      hold_drain = 1'b1;
    end else if (!cache_done) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IF_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      drop_pc    <= '0;
      ifid       <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drop       <= drop_nxt;
      drop_pc    <= drop_pc_nxt;
      ifid       <= ifid_nxt;
      inst_valid <= valid_nxt;
      halted     <= halted_nxt;
    end
  end

  assign instruction = ifid.instruction;
  assign PC_plus_4   = ifid.PC_plus_4;

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage against an architectural fetch-stream model.
module tb_if_stage;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cache_done, imem_ready, redirect, halt;
  logic [31:0] redirect_pc;
  logic        imem_req, inst_valid, halted;
  logic [31:0] imem_addr, imem_data, instruction, PC_plus_4;

  logic        w_ready, w_cd, w_redir, w_halt;
  logic [31:0] w_rpc;
  logic        w_req, w_valid, w_halted;
  logic [31:0] w_addr, w_data, w_instr, w_pc4;

  assign imem_data = imem_addr ^ KEY;
  assign w_data    = w_addr ^ KEY;

  if_stage dut (
    .clk(clk), .rst(rst), .cache_done(cache_done),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instruction(instruction), .PC_plus_4(PC_plus_4), .inst_valid(inst_valid), .halted(halted)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .cache_done(w_cd),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready), .imem_data(w_data),
    .redirect(w_redir), .redirect_pc(w_rpc), .halt(w_halt),
    .instruction(w_instr), .PC_plus_4(w_pc4), .inst_valid(w_valid), .halted(w_halted)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: expected delivery stream plus the address the fetcher should present.
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
  } exp_t;
  exp_t        q[$];
  logic [31:0] fetch_pc, squash_addr;
  bit          squash, m_held, m_halted, run_mon;
  int          lat, cnt;
  logic        req_seen;

  task automatic model_reset();
    q.delete();
    fetch_pc = 32'h0;
    squash   = 1'b0;
    m_held   = 1'b0;
    m_halted = 1'b0;
    cnt      = 0;
  endtask

  task automatic model_step();
    bit req_exp;
    exp_t e;
    req_exp = !m_halted && !m_held;
    if (m_halted) return;
    if (!cache_done && redirect) begin
      q.delete();
      m_held = 1'b0;
      if (req_exp && !imem_ready) begin
        if (!squash) squash_addr = fetch_pc;
        squash = 1'b1;
      end else begin
        squash = 1'b0;
      end
      fetch_pc = redirect_pc;
    end else if (!cache_done && halt) begin
      q.delete();
      m_held   = 1'b0;
      squash   = 1'b0;
      m_halted = 1'b1;
    end else if (imem_ready) begin
      if (squash) begin
        squash = 1'b0;
      end else begin
        e.ins = fetch_pc ^ KEY;
        e.pc4 = fetch_pc + 32'd4;
        q.push_back(e);
        fetch_pc = fetch_pc + 32'd4;
        if (cache_done) m_held = 1'b1;
      end
    end else if (!cache_done) begin
      m_held = 1'b0;
    end
  endtask

  // Monitor: compares handshake outputs each cycle and pops the scoreboard on each consumed entry.
  always @(negedge clk) begin
    if (run_mon && !rst) begin
      exp_t e;
      int held_n;
      held_n = m_held ? 1 : 0;
      check("imem_req", 32'(imem_req), 32'(!m_halted && !m_held));
      check("halted", 32'(halted), 32'(m_halted));
      check("inst_valid", 32'(inst_valid), 32'(q.size() > held_n));
      if (imem_req && imem_ready)
        check("imem_addr", imem_addr, squash ? squash_addr : fetch_pc);
      if (inst_valid && !cache_done && q.size() > held_n) begin
        e = q.pop_front();
        check("instruction", instruction, e.ins);
        check("PC_plus_4", PC_plus_4, e.pc4);
      end
    end
  end

  initial begin
    int freeze_left;
    rst = 1'b1; cache_done = 1'b0; imem_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
    redirect_pc = '0; run_mon = 1'b0; lat = 0; req_seen = 1'b0; freeze_left = 0;
    w_ready = 1'b1; w_cd = 1'b0; w_redir = 1'b0; w_halt = 1'b0; w_rpc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst imem_req", 32'(imem_req), 32'h0);
    check("rst inst_valid", 32'(inst_valid), 32'h0);
    check("rst instruction", instruction, 32'h0);
    check("rst PC_plus_4", PC_plus_4, 32'h0);
    check("rst halted", 32'(halted), 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst wrap addr", w_addr, 32'hFFFF_FFFC);

    for (int ep = 0; ep < 6; ep++) begin
      rst = 1'b1; run_mon = 1'b0; imem_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      lat = (ep == 0) ? 0 : int'($urandom_range(0, 3));
      #1 rst = 1'b0;
      run_mon = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
        #1;
        if (ep == 0 && cyc < 3) begin
          check("wrap req", 32'(w_req), 32'h1);
          if (cyc == 0) check("wrap first addr", w_addr, 32'hFFFF_FFFC);
          if (cyc == 1) begin
            check("wrap instr", w_instr, 32'hFFFF_FFFC ^ KEY);
            check("wrap PC_plus_4", w_pc4, 32'h0);
            check("wrap next addr", w_addr, 32'h0);
          end
          if (cyc == 2) check("wrap second PC_plus_4", w_pc4, 32'h4);
        end
        if (freeze_left > 0) begin
          cache_done = 1'b1;
          freeze_left--;
        end else if (ep == 0 && cyc < 20) begin
          cache_done = 1'b0;
        end else begin
          cache_done = 1'b0;
          if ($urandom_range(0, 9) == 0) freeze_left = int'($urandom_range(1, 4));
        end
        redirect = (cyc >= 20) && ($urandom_range(0, 15) == 0);
        halt     = (cyc >= 150) && ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF8;
        else redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if (cyc == 60) begin
          cache_done = 1'b0; redirect = 1'b1; halt = 1'b1; redirect_pc = 32'h40; freeze_left = 0;
        end
        req_seen   = imem_req;
        imem_ready = imem_req && (cnt >= lat);
        @(posedge clk);
        model_step();
        if (imem_ready) begin
          cnt = 0;
          if (ep > 0) lat = int'($urandom_range(0, 3));
        end else if (req_seen) begin
          cnt++;
        end else begin
          cnt = 0;
        end
      end
    end
    run_mon = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage with PC register, instruction-memory request handshake and IF/ID pipeline register. It sits directly upstream of the ID/EX register and feeds decode with `instruction`, `PC_plus_4` and a valid bit. It honours the global freeze `cache_done`, accepts branch/jump redirects resolved downstream, and stops fetching on halt.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `cache_done` in 1: pipeline freeze, same polarity as the rest of the pipeline. 1 = hold the IF/ID register, 0 = advance.
- `imem_req` out 1: fetch request; `imem_addr` is valid while this is high.
- `imem_addr` out 32: fetch address, equal to the internal PC.
- `imem_ready` in 1: response strobe. A request completes on any posedge where `imem_req` and `imem_ready` are both 1.
- `imem_data` in 32: instruction word, valid with `imem_ready`.
- `redirect` in 1: taken branch or jump; load `redirect_pc`.
- `redirect_pc` in 32: redirect target.
- `halt` in 1: decode has seen a halt instruction.
- `instruction` out 32: IF/ID instruction.
- `PC_plus_4` out 32: IF/ID address of the fetched instruction + 4.
- `inst_valid` out 1: IF/ID entry valid; 0 = bubble.
- `halted` out 1: sticky halt status.

## Operation
- Reset values: pc=`RESET_PC`, state=IF_REQ, `instruction`=0, `PC_plus_4`=0, `inst_valid`=0, `halted`=0, hold buffer empty, drop flag 0. `imem_req`=0 while `rst`=1.
- The FSM has two states: IF_REQ and IF_HALTED.
- `imem_req` = (state==IF_REQ) && !hold_valid && !rst.
- `imem_addr` is stable until completion. pc never changes while a request is outstanding, except by redirect; a redirect sets the drop flag instead of moving the address.
- Completion with `cache_done`=0, no redirect, drop flag 0:
  - `instruction` <= `imem_data`, `PC_plus_4` <= pc+4, `inst_valid` <= 1.
  - pc <= pc+4.
- Completion with `cache_done`=1: the word and pc+4 go into the one-entry hold buffer and hold_valid <= 1. pc <= pc+4. The IF/ID register is unchanged.
- `cache_done`=0 with hold_valid=1: the buffer moves to IF/ID with `inst_valid`=1, and hold_valid <= 0.
- `cache_done`=0 with nothing to load: `inst_valid` <= 0 (bubble).
- `cache_done`=1 with no completion: all IF/ID outputs hold.
- `redirect` and `halt` are sampled only when `cache_done`=0.
- Redirect:
  - pc <= `redirect_pc`, `inst_valid` <= 0, hold buffer cleared.
  - If a request is outstanding and `imem_ready`=0 this cycle, drop flag <= 1. The next completion is discarded and clears the flag; pc does not advance. The request at `redirect_pc` follows.
  - If `imem_ready`=1 in the same cycle, that data is discarded.
- Halt (`halt`=1, no redirect): state <= IF_HALTED, `halted` <= 1, `inst_valid` <= 0, hold buffer cleared. Remains halted until `rst`.
- Redirect and halt in the same cycle: redirect wins, because the halt belongs to a younger, squashed instruction.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- `rst` mid-request: the outstanding response is not tracked; the memory model must abort on `rst`.

## Timing
- Zero-wait memory (`imem_ready` tied 1): one instruction per cycle. IF/ID is valid one cycle after address presentation.
- N-cycle memory: `inst_valid` pulses for one cycle per completion, with bubbles between.
- Redirect with no outstanding request: the new address is on `imem_addr` the cycle after the redirect edge.
- Redirect with an outstanding request: the new address appears the cycle after the dropped response.
- Freeze release: the buffered instruction appears in IF/ID on the first edge with `cache_done`=0. A new request is issued in that same cycle.

## Structure
- Shared package `if_pkg`:
  - enum `if_state_t` {IF_REQ, IF_HALTED}.
  - constant `PC_INC` = 32'd4.
  - typedef `if_id_t` {instruction, PC_plus_4}.
- Sub-module `if_hold_buf`: one-entry buffer of `if_id_t` with load, drain and clear inputs, and a `hold_valid` output.

## Test plan
- Reset, `imem_ready`=1, `cache_done`=0, memory returns addr as data: `instruction` = 0, 4, 8 on consecutive cycles; `PC_plus_4` = 4, 8, 12.
- `cache_done`=1 for 3 cycles while a response arrives at pc 0x10: outputs frozen, `imem_req`=0 after capture. On release, `instruction`=mem[0x10], `PC_plus_4`=0x14, then fetch 0x14.
- 3-cycle memory; redirect to 0x100 one cycle into the request at 0x20: response for 0x20 dropped, next `imem_addr`=0x100, no valid instruction from 0x20.
- `redirect` and `halt` together (target 0x40): `halted` stays 0 and fetch resumes at 0x40. `halt` alone: `halted`=1, `imem_req`=0, `inst_valid`=0 until `rst`.
- `RESET_PC`=32'hFFFF_FFFC: first fetch 0xFFFF_FFFC, `PC_plus_4`=0, next `imem_addr`=0.
